// File: rtl/ahb_sram_slave_if.sv
`timescale 1ns/1ps
// AHB-Lite slave front end for an SRAM controller: one request pulse per legal
// transfer, two-cycle ERROR response for out-of-range or misaligned accesses.
module ahb_sram_slave_if #(
  parameter int AHB_DWIDTH = 32,
  parameter int MEM_BYTES  = 2048
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic [19:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic                  HREADYIN,
  input  logic [AHB_DWIDTH-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [AHB_DWIDTH-1:0] HRDATA,
  output logic                  ahbsram_req,
  output logic                  ahbsram_write,
  output logic [2:0]            ahbsram_size,
  output logic [19:0]           ahbsram_addr,
  output logic [AHB_DWIDTH-1:0] ahbsram_wdata,
  input  logic                  sramahb_ack,
  input  logic [AHB_DWIDTH-1:0] sramahb_rdata,
  input  logic                  BUSY
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ERR1, S_ERR2} state_t;

  localparam logic [20:0] MEM_LIMIT = 21'(MEM_BYTES);

  state_t                state_q, state_d;
  logic [19:0]           addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic [AHB_DWIDTH-1:0] wdata_q, wdata_d;

  logic accept;
  logic illegal;
  logic can_accept;
  logic unused_htrans0;

  // HTRANS[0] only separates SEQ from NONSEQ, which this slave treats alike.
  assign unused_htrans0 = HTRANS[0];
  assign accept         = HSEL & HREADYIN & HTRANS[1];

  always_comb begin
    illegal = ({1'b0, HADDR} >= MEM_LIMIT)
           || (HSIZE > 3'b010)
           || ((HSIZE == 3'b001) && HADDR[0])
           || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    size_d        = size_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    can_accept    = 1'b0;
    HREADYOUT     = 1'b1;
    HRESP         = 2'b00;
    HRDATA        = '0;
    ahbsram_req   = 1'b0;
    ahbsram_wdata = wdata_q;

    case (state_q)
      S_IDLE: can_accept = 1'b1;
      S_REQ: begin
        HREADYOUT = 1'b0;
        if (!BUSY) begin
          ahbsram_req   = 1'b1;
          ahbsram_wdata = HWDATA;
          wdata_d       = HWDATA;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        HREADYOUT = sramahb_ack;
        if (sramahb_ack) begin
          can_accept = 1'b1;
          state_d    = S_IDLE;
          if (!write_q) HRDATA = sramahb_rdata;
        end
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 2'b01;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        HRESP      = 2'b01;
        can_accept = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // New address phases are only taken in cycles where this slave drives HREADYOUT high.
    if (can_accept && accept) begin
      addr_d  = HADDR;
      size_d  = HSIZE;
      write_d = HWRITE;
      state_d = illegal ? S_ERR1 : S_REQ;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  assign ahbsram_addr  = addr_q;
  assign ahbsram_size  = size_q;
  assign ahbsram_write = write_q;

endmodule
